// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: host request/response bus of the framebuffer arbiter.
// The arbiter connects to the slave modport and the host to the master modport.
interface vga_fb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, we, addr, wdata, input  ready, rvalid, rdata);
    modport slave  (input  valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer RAM between the 4x-scaled VGA fetch path
// and a host port. Define VGA_ARB_HOST_READ_EN to build host read support.
module vga_fb_arbiter #(
    parameter int DATA_W = 8,
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcount_i,
    input  logic [9:0]        vcount_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              hblank_i,
    input  logic              vblank_i,
    vga_fb_arbiter_if.slave   host_if,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] pixel_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              blank_o
);

    typedef enum logic [1:0] {G_NONE, G_DISP, G_HOST} grant_t;

    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W + 1)'(FB_W * FB_H);

    grant_t            grant_q, grant_d;
    logic              pend_q, pend_d;
    logic              pendWe_q, pendWe_d;
    logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
    logic [DATA_W-1:0] pendWdata_q, pendWdata_d;
    logic              memEn_q, memEn_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              dispRet_q;
    logic [DATA_W-1:0] pix_q;
    logic [2:0]        hsDly_q, vsDly_q, hbDly_q, vbDly_q;

    logic              dispSlot;
    logic              hostWe;
    logic              inRange;
    logic [ADDR_W-1:0] rowExt, colExt, dispAddr;

    assign dispSlot = !hblank_i && !vblank_i && (hcount_i[1:0] == 2'b00);
    assign rowExt   = ADDR_W'(vcount_i >> 2);
    assign colExt   = ADDR_W'(hcount_i >> 2);
    assign inRange  = ({1'b0, host_if.addr} < FB_SIZE);

    // 160 = 128 + 32, so the row offset needs only two shifts and an add
    if (FB_W == 160) begin : gShiftAdd
        assign dispAddr = (rowExt << 7) + (rowExt << 5) + colExt;
    end else begin : gConstMul
        assign dispAddr = rowExt * ADDR_W'(FB_W) + colExt;
    end

`ifdef VGA_ARB_HOST_READ_EN
    assign hostWe = host_if.we;
`else
    // write-only build: host_we is ignored and every request becomes a write
    assign hostWe = host_if.we | 1'b1;
`endif

    always_comb begin
        grant_d     = G_NONE;
        pend_d      = pend_q;
        pendWe_d    = pendWe_q;
        pendAddr_d  = pendAddr_q;
        pendWdata_d = pendWdata_q;
        memEn_d     = 1'b0;
        memWe_d     = 1'b0;
        memAddr_d   = '0;
        memWdata_d  = '0;

        if (dispSlot) begin
            grant_d = G_DISP;
        end else if (pend_q) begin
            grant_d = G_HOST;
        end

        case (grant_d)
            G_DISP: begin
                memEn_d   = 1'b1;
                memAddr_d = dispAddr;
            end
            G_HOST: begin
                memEn_d    = 1'b1;
                memWe_d    = pendWe_q;
                memAddr_d  = pendAddr_q;
                memWdata_d = pendWdata_q;
                pend_d     = 1'b0;
            end
            default: ;
        endcase

        // out-of-range requests are accepted but never become pending
        if (host_if.valid && !pend_q) begin
            pend_d      = inRange;
            pendWe_d    = hostWe;
            pendAddr_d  = host_if.addr;
            pendWdata_d = host_if.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= G_NONE;
            pend_q      <= 1'b0;
            pendWe_q    <= 1'b0;
            pendAddr_q  <= '0;
            pendWdata_q <= '0;
            memEn_q     <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            dispRet_q   <= 1'b0;
            pix_q       <= '0;
            hsDly_q     <= '1;
            vsDly_q     <= '1;
            hbDly_q     <= '1;
            vbDly_q     <= '1;
        end else begin
            grant_q     <= grant_d;
            pend_q      <= pend_d;
            pendWe_q    <= pendWe_d;
            pendAddr_q  <= pendAddr_d;
            pendWdata_q <= pendWdata_d;
            memEn_q     <= memEn_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            dispRet_q   <= (grant_q == G_DISP);
            if (dispRet_q) begin
                pix_q <= mem_rdata_i;
            end
            hsDly_q <= {hsDly_q[1:0], hsync_i};
            vsDly_q <= {vsDly_q[1:0], vsync_i};
            hbDly_q <= {hbDly_q[1:0], hblank_i};
            vbDly_q <= {vbDly_q[1:0], vblank_i};
        end
    end

`ifdef VGA_ARB_HOST_READ_EN
    // marks the cycle in which RAM data for a host read is on mem_rdata_i
    logic rdRet_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdRet_q <= 1'b0;
        end else begin
            rdRet_q <= (grant_q == G_HOST) && !memWe_q;
        end
    end

    assign host_if.rvalid = rdRet_q;
    assign host_if.rdata  = rdRet_q ? mem_rdata_i : '0;
`else
    assign host_if.rvalid = 1'b0;
    assign host_if.rdata  = '0;
`endif

    assign host_if.ready = !pend_q;
    assign mem_en_o      = memEn_q;
    assign mem_we_o      = memWe_q;
    assign mem_addr_o    = memAddr_q;
    assign mem_wdata_o   = memWdata_q;
    assign hsync_o       = hsDly_q[2];
    assign vsync_o       = vsDly_q[2];
    assign blank_o       = hbDly_q[2] | vbDly_q[2];
    assign pixel_o       = blank_o ? '0 : pix_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for vga_fb_arbiter with scoreboards for RAM accesses
// and for the aligned pixel/sync outputs, plus direct host handshake checks.
module tb_vga_fb_arbiter;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 15;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [9:0]        hcount   = 10'd700;
    logic [9:0]        vcount   = 10'd500;
    logic              hsyncIn  = 1'b1;
    logic              vsyncIn  = 1'b1;
    logic              hblankIn = 1'b1;
    logic              vblankIn = 1'b1;
    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata = '0;
    logic [DATA_W-1:0] pixel;
    logic              hsync, vsync, blank;
    logic [DATA_W-1:0] ram [0:32767];

    int cycleCnt = 0;
    int compCnt  = 0;
    int errCnt   = 0;

    typedef struct {
        int                cyc;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memExp_t;

    typedef struct {
        int                cyc;
        logic              hs;
        logic              vs;
        logic              bl;
        logic [DATA_W-1:0] pix;
    } vidExp_t;

    memExp_t memQ[$];
    vidExp_t vidQ[$];
    memExp_t mE;
    vidExp_t vE;

    vga_fb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hostIf ();

    vga_fb_arbiter #(
        .DATA_W(DATA_W),
        .FB_W  (160),
        .FB_H  (120),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_i   (hcount),
        .vcount_i   (vcount),
        .hsync_i    (hsyncIn),
        .vsync_i    (vsyncIn),
        .hblank_i   (hblankIn),
        .vblank_i   (vblankIn),
        .host_if    (hostIf),
        .mem_en_o   (memEn),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata),
        .pixel_o    (pixel),
        .hsync_o    (hsync),
        .vsync_o    (vsync),
        .blank_o    (blank)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // single-port synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (memEn === 1'b1) begin
            if (memWe) begin
                ram[memAddr] <= memWdata;
            end else begin
                memRdata <= ram[memAddr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (memQ.size() > 0 && memQ[0].cyc == cycleCnt) begin
            mE = memQ.pop_front();
            checkOutput("mem_en", 32'(memEn), 32'd1);
            checkOutput("mem_we", 32'(memWe), 32'(mE.we));
            checkOutput("mem_addr", 32'(memAddr), 32'(mE.addr));
            checkOutput("mem_wdata", 32'(memWdata), 32'(mE.wdata));
        end else if (memEn === 1'b1) begin
            checkOutput("mem_unexpected", 32'(memEn), 32'd0);
        end
        if (vidQ.size() > 0 && vidQ[0].cyc == cycleCnt) begin
            vE = vidQ.pop_front();
            checkOutput("pixel", 32'(pixel), 32'(vE.pix));
            checkOutput("hsync", 32'(hsync), 32'(vE.hs));
            checkOutput("vsync", 32'(vsync), 32'(vE.vs));
            checkOutput("blank", 32'(blank), 32'(vE.bl));
        end
    end

    // drives one cycle of sync-generator inputs and queues the output due three cycles later
    task automatic applyStimulus(input int hc, input int vc, input int hs, input int vs,
                                 input int hb, input int vb, input int expPix);
        vidExp_t v;
        @(posedge clk);
        #1;
        hcount   = 10'(hc);
        vcount   = 10'(vc);
        hsyncIn  = (hs != 0);
        vsyncIn  = (vs != 0);
        hblankIn = (hb != 0);
        vblankIn = (vb != 0);
        v.cyc = cycleCnt + 3;
        v.hs  = (hs != 0);
        v.vs  = (vs != 0);
        v.bl  = (hb != 0) || (vb != 0);
        v.pix = 8'(expPix);
        vidQ.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(700, 500, 1, 1, 1, 1, 0);
        end
    endtask

    task automatic setHost(input int v, input int we, input int addr, input int wdata);
        hostIf.valid = (v != 0);
        hostIf.we    = (we != 0);
        hostIf.addr  = ADDR_W'(addr);
        hostIf.wdata = 8'(wdata);
    endtask

    task automatic expectMem(input int offset, input int we, input int addr, input int wdata);
        memExp_t m;
        m.cyc   = cycleCnt + offset;
        m.we    = (we != 0);
        m.addr  = ADDR_W'(addr);
        m.wdata = 8'(wdata);
        memQ.push_back(m);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i] = '0;
        end
        ram[162]   = 8'hA5;
        ram[163]   = 8'h5A;
        ram[19199] = 8'hC3;
        ram[320]   = 8'h81;
        ram[321]   = 8'h42;
        ram[5]     = 8'h77;
        setHost(1, 1, 3, 'h11);
        $display("[TB] start");

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("rst_ready", 32'(hostIf.ready), 32'd1);
            checkOutput("rst_mem_en", 32'(memEn), 32'd0);
            checkOutput("rst_pixel", 32'(pixel), 32'd0);
            checkOutput("rst_hsync", 32'(hsync), 32'd1);
            checkOutput("rst_vsync", 32'(vsync), 32'd1);
            checkOutput("rst_blank", 32'(blank), 32'd1);
        end
        idle(1);
        rst = 1'b0;
        setHost(0, 1, 0, 0);
        idle(3);

        // scaled fetch on line 4, then the bottom-right corner, then into hblank
        for (int hc = 8; hc < 16; hc++) begin
            applyStimulus(hc, 4, 1, 1, 0, 0, (hc < 12) ? 'hA5 : 'h5A);
            if (hc == 8)  expectMem(1, 0, 162, 0);
            if (hc == 12) expectMem(1, 0, 163, 0);
        end
        for (int hc = 636; hc < 640; hc++) begin
            applyStimulus(hc, 479, 1, 1, 0, 0, 'hC3);
            if (hc == 636) expectMem(1, 0, 19199, 0);
        end
        for (int hc = 640; hc < 644; hc++) begin
            applyStimulus(hc, 479, (hc >= 642) ? 0 : 1, 1, 1, 0, 0);
        end

        // host write accepted in the cycle before a display slot
        for (int hc = 0; hc < 8; hc++) begin
            applyStimulus(hc, 8, 1, 1, 0, 0, (hc < 4) ? 'h81 : 'h42);
            if (hc == 0) expectMem(1, 0, 320, 0);
            if (hc == 3) setHost(1, 1, 'h0100, 'h3C);
            if (hc == 4) begin
                setHost(0, 1, 0, 0);
                expectMem(1, 0, 321, 0);
                expectMem(2, 1, 'h0100, 'h3C);
            end
            if (hc >= 3 && hc <= 6) begin
                @(negedge clk);
                checkOutput($sformatf("coll_ready_h%0d", hc), 32'(hostIf.ready),
                            (hc == 4 || hc == 5) ? 32'd0 : 32'd1);
            end
        end
        applyStimulus(640, 8, 1, 1, 1, 0, 0);
        applyStimulus(700, 490, 1, 0, 1, 1, 0);
        applyStimulus(700, 491, 1, 0, 1, 1, 0);
        idle(3);

        // out-of-range write is swallowed without a RAM access
        idle(1);
        setHost(1, 1, 19200, 'hEE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("oor_ready_%0d", i), 32'(hostIf.ready), 32'd1);
            if (i == 0) begin
                idle(1);
                setHost(0, 1, 0, 0);
            end else begin
                idle(1);
            end
        end

        // last valid address is a real write
        idle(1);
        setHost(1, 1, 19199, 'h99);
        expectMem(2, 1, 19199, 'h99);
        idle(1);
        setHost(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("edge_ready_busy", 32'(hostIf.ready), 32'd0);
        idle(3);

        // host read request during vblank
        idle(1);
`ifdef VGA_ARB_HOST_READ_EN
        setHost(1, 0, 5, 0);
        expectMem(2, 0, 5, 0);
`else
        setHost(1, 0, 5, 'h12);
        expectMem(2, 1, 5, 'h12);
`endif
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            if (i == 1) setHost(0, 1, 0, 0);
            @(negedge clk);
`ifdef VGA_ARB_HOST_READ_EN
            checkOutput($sformatf("rd_rvalid_%0d", i), 32'(hostIf.rvalid), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) checkOutput("rd_rdata", 32'(hostIf.rdata), 32'h77);
`else
            checkOutput($sformatf("rd_rvalid_%0d", i), 32'(hostIf.rvalid), 32'd0);
            checkOutput($sformatf("rd_rdata_%0d", i), 32'(hostIf.rdata), 32'd0);
`endif
        end
        idle(3);

        // reset while a write is pending discards it
        idle(1);
        setHost(1, 1, 'h0200, 'h55);
        idle(1);
        setHost(0, 1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_busy", 32'(hostIf.ready), 32'd0);
        idle(1);
        @(negedge clk);
        checkOutput("midrst_ready_after", 32'(hostIf.ready), 32'd1);
        idle(1);
        rst = 1'b0;
        idle(5);
        @(negedge clk);
        checkOutput("midrst_ready_end", 32'(hostIf.ready), 32'd1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("memq_drained", 32'(memQ.size()), 32'd0);
        checkOutput("vidq_drained", 32'(vidQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
        $finish;
    end

endmodule
